// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, registered sync/enable decode,
// and a ce-gated delay line that re-aligns sync/enable with downstream colour pipelines.
module vga_timing_gen #(
  parameter int   H_VISIBLE  = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_VISIBLE  = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   SYNC_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       display,
  output logic [9:0] oX,
  output logic [9:0] oY,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  localparam logic [2:0] SYNC_IDLE = {~HS_POL, ~VS_POL, 1'b0};

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       de_q, de_d;
  logic       ls_q, ls_d;
  logic       fs_q, fs_d;

  // Decode is taken from the next counter values so it lands together with oX/oY.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    hs_d = hs_q;
    vs_d = vs_q;
    de_d = de_q;
    ls_d = 1'b0;
    fs_d = 1'b0;
    if (ce) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d = '0;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
      de_d = (x_d < H_VIS) && (y_d < V_VIS);
      hs_d = ((x_d >= HS_START) && (x_d < HS_END)) ? HS_POL : ~HS_POL;
      vs_d = ((y_d >= VS_START) && (y_d < VS_END)) ? VS_POL : ~VS_POL;
      ls_d = (x_d == 10'd0);
      fs_d = (x_d == 10'd0) && (y_d == 10'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign oX          = x_q;
  assign oY          = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign {VGA_HS, VGA_VS, display} = {hs_q, vs_q, de_q};
    end else begin : g_delay
      logic [2:0] dly_q [SYNC_DELAY];
      logic [2:0] dly_d [SYNC_DELAY];

      // Shift stages move only on pixel steps, so the delay is counted in pixels, not clocks.
      always_comb begin
        dly_d = dly_q;
        if (ce) begin
          dly_d[0] = {hs_q, vs_q, de_q};
          for (int i = 1; i < SYNC_DELAY; i++) begin
            dly_d[i] = dly_q[i-1];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_DELAY; i++) begin
            dly_q[i] <= SYNC_IDLE;
          end
        end else begin
          dly_q <= dly_d;
        end
      end

      assign {VGA_HS, VGA_VS, display} = dly_q[SYNC_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: two full-size instances (delay 0 and 2) and a
// miniature raster instance, all checked against a pixel-step-count reference model.
module tb_vga_timing_gen;

  typedef struct {
    int   hv, hfp, hsync, hbp;
    int   vv, vfp, vsync, vbp;
    logic hpol, vpol;
    int   dly;
  } cfg_t;

  typedef struct {
    int   x, y;
    logic hs, vs, de, ls, fs;
  } exp_t;

  typedef struct {
    logic rst, ce;
    int   x;
    logic hs, de, ls;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic ce;

  logic [2:0] hs_o, vs_o, de_o, ls_o, fs_o;
  logic [9:0] x_o [3];
  logic [9:0] y_o [3];

  cfg_t cfg [3];
  vec_t tbl [8];

  int   n;
  logic pflag;
  int   checks;
  int   fails;
  int   ls_count;

  always #5 clk = ~clk;

  vga_timing_gen #(.SYNC_DELAY(0)) u_dut0 (
    .clk(clk), .rst(rst), .ce(ce),
    .VGA_HS(hs_o[0]), .VGA_VS(vs_o[0]), .display(de_o[0]),
    .oX(x_o[0]), .oY(y_o[0]), .line_start(ls_o[0]), .frame_start(fs_o[0])
  );

  vga_timing_gen #(.SYNC_DELAY(2)) u_dut2 (
    .clk(clk), .rst(rst), .ce(ce),
    .VGA_HS(hs_o[1]), .VGA_VS(vs_o[1]), .display(de_o[1]),
    .oX(x_o[1]), .oY(y_o[1]), .line_start(ls_o[1]), .frame_start(fs_o[1])
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b0), .SYNC_DELAY(1)
  ) u_small (
    .clk(clk), .rst(rst), .ce(ce),
    .VGA_HS(hs_o[2]), .VGA_VS(vs_o[2]), .display(de_o[2]),
    .oX(x_o[2]), .oY(y_o[2]), .line_start(ls_o[2]), .frame_start(fs_o[2])
  );

  // Reference: everything follows from the number of pixel steps since reset.
  function automatic exp_t modelOut(input cfg_t c, input int steps, input logic pf);
    exp_t e;
    int ht, vt, k, kx, ky;
    ht   = c.hv + c.hfp + c.hsync + c.hbp;
    vt   = c.vv + c.vfp + c.vsync + c.vbp;
    e.x  = steps % ht;
    e.y  = (steps / ht) % vt;
    e.ls = pf && (e.x == 0);
    e.fs = pf && (e.x == 0) && (e.y == 0);
    k    = steps - c.dly;
    if (k <= 0) begin
      e.hs = ~c.hpol;
      e.vs = ~c.vpol;
      e.de = 1'b0;
    end else begin
      kx   = k % ht;
      ky   = (k / ht) % vt;
      e.de = (kx < c.hv) && (ky < c.vv);
      e.hs = (kx >= c.hv + c.hfp && kx < c.hv + c.hfp + c.hsync) ? c.hpol : ~c.hpol;
      e.vs = (ky >= c.vv + c.vfp && ky < c.vv + c.vfp + c.vsync) ? c.vpol : ~c.vpol;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (step %0d, t=%0t)", name, got, exp, n, $time);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      e = modelOut(cfg[d], n, pflag);
      check($sformatf("dut%0d oX", d),          32'(x_o[d]),  32'(e.x));
      check($sformatf("dut%0d oY", d),          32'(y_o[d]),  32'(e.y));
      check($sformatf("dut%0d VGA_HS", d),      32'(hs_o[d]), 32'(e.hs));
      check($sformatf("dut%0d VGA_VS", d),      32'(vs_o[d]), 32'(e.vs));
      check($sformatf("dut%0d display", d),     32'(de_o[d]), 32'(e.de));
      check($sformatf("dut%0d line_start", d),  32'(ls_o[d]), 32'(e.ls));
      check($sformatf("dut%0d frame_start", d), 32'(fs_o[d]), 32'(e.fs));
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle before checking.
  task automatic applyStimulus(input logic r, input logic c);
    rst = r;
    ce  = c;
    @(posedge clk);
    if (r) begin
      n     = 0;
      pflag = 1'b0;
    end else if (c) begin
      n++;
      pflag = 1'b1;
    end else begin
      pflag = 1'b0;
    end
    #1;
  endtask

  task automatic advanceTo(input int target, input string name);
    int k;
    k = 0;
    while (int'(x_o[0]) != target && k < 2000) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput();
      k++;
    end
    check(name, 32'(x_o[0]), 32'(target));
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    n      = 0;
    pflag  = 1'b0;
    rst    = 1'b1;
    ce     = 1'b1;

    cfg[0] = '{hv:640, hfp:16, hsync:96, hbp:48, vv:480, vfp:10, vsync:2, vbp:33,
               hpol:1'b0, vpol:1'b0, dly:0};
    cfg[1] = cfg[0];
    cfg[1].dly = 2;
    cfg[2] = '{hv:8, hfp:2, hsync:3, hbp:2, vv:6, vfp:2, vsync:2, vbp:3,
               hpol:1'b1, vpol:1'b0, dly:1};

    tbl[0] = '{rst:1'b1, ce:1'b1, x:0, hs:1'b1, de:1'b0, ls:1'b0};
    tbl[1] = '{rst:1'b1, ce:1'b1, x:0, hs:1'b1, de:1'b0, ls:1'b0};
    tbl[2] = '{rst:1'b1, ce:1'b1, x:0, hs:1'b1, de:1'b0, ls:1'b0};
    tbl[3] = '{rst:1'b0, ce:1'b1, x:1, hs:1'b1, de:1'b1, ls:1'b0};
    tbl[4] = '{rst:1'b0, ce:1'b0, x:1, hs:1'b1, de:1'b1, ls:1'b0};
    tbl[5] = '{rst:1'b0, ce:1'b1, x:2, hs:1'b1, de:1'b1, ls:1'b0};
    tbl[6] = '{rst:1'b0, ce:1'b0, x:2, hs:1'b1, de:1'b1, ls:1'b0};
    tbl[7] = '{rst:1'b0, ce:1'b1, x:3, hs:1'b1, de:1'b1, ls:1'b0};

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].ce);
      check("table oX",         32'(x_o[0]),  32'(tbl[i].x));
      check("table oY",         32'(y_o[0]),  32'd0);
      check("table VGA_HS",     32'(hs_o[0]), 32'(tbl[i].hs));
      check("table display",    32'(de_o[0]), 32'(tbl[i].de));
      check("table line_start", 32'(ls_o[0]), 32'(tbl[i].ls));
      checkOutput();
    end

    // ce toggling 1,0,1,0: one pixel per two clocks
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, (i % 2) == 0);
      check("ce toggle oX", 32'(x_o[0]), 32'(4 + i / 2));
      checkOutput();
    end

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'b0, $urandom_range(0, 3) != 0);
      checkOutput();
    end

    advanceTo(300, "reach oX=300");
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 1'b0);
      check("hold oX",         32'(x_o[0]),  32'd300);
      check("hold VGA_HS",     32'(hs_o[0]), 32'd1);
      check("hold line_start", 32'(ls_o[0]), 32'd0);
      checkOutput();
    end

    // Delay-line alignment: delayed instance lags the undelayed one by exactly 2 steps
    advanceTo(639, "reach oX=639");
    applyStimulus(1'b0, 1'b1);
    check("de fall d0 @640", 32'(de_o[0]), 32'd0);
    check("de d2 @640",      32'(de_o[1]), 32'd1);
    applyStimulus(1'b0, 1'b1);
    check("de d2 @641",      32'(de_o[1]), 32'd1);
    applyStimulus(1'b0, 1'b1);
    check("de fall d2 @642", 32'(de_o[1]), 32'd0);
    advanceTo(655, "reach oX=655");
    applyStimulus(1'b0, 1'b1);
    check("hs fall d0 @656", 32'(hs_o[0]), 32'd0);
    check("hs d2 @656",      32'(hs_o[1]), 32'd1);
    applyStimulus(1'b0, 1'b1);
    check("hs d2 @657",      32'(hs_o[1]), 32'd1);
    applyStimulus(1'b0, 1'b1);
    check("hs fall d2 @658", 32'(hs_o[1]), 32'd0);
    checkOutput();

    ls_count = 0;
    for (int i = 0; i < 1600; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (ls_o[0] === 1'b1) ls_count++;
      checkOutput();
    end
    check("line_start per 1600 steps", 32'(ls_count), 32'd2);

    // Mid-frame reset must take effect without waiting for a clock edge
    advanceTo(400, "reach oX=400");
    rst = 1'b1;
    #1;
    n     = 0;
    pflag = 1'b0;
    check("async reset oX",     32'(x_o[0]),  32'd0);
    check("async reset VGA_HS", 32'(hs_o[0]), 32'd1);
    checkOutput();
    applyStimulus(1'b1, 1'b1);
    checkOutput();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b1);
      check("restart oX", 32'(x_o[0]), 32'(i));
      check("restart oY", 32'(y_o[0]), 32'd0);
      checkOutput();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
